// File: rtl/att_clause_walker.sv
// Walks the clause mask of one Address_Translation_Table entry per request
// and streams one clause descriptor per set mask bit, lowest bit first.
module att_clause_walker #(
    parameter int CLAUSE_COUNT               = 20,
    parameter int LITERAL_ADDRESS_WIDTH      = 12,
    parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11,
    localparam int CLAUSE_INDEX_WIDTH =
        (CLAUSE_COUNT > 1) ? $clog2(CLAUSE_COUNT) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [LITERAL_ADDRESS_WIDTH-1:0]      req_literal_i,
    output logic [LITERAL_ADDRESS_WIDTH-1:0]      att_rd_addr_o,
    input  logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] att_addr_i,
    input  logic [CLAUSE_COUNT-1:0]               att_mask_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] out_clause_addr_o,
    output logic [CLAUSE_INDEX_WIDTH-1:0]         out_clause_idx_o,
    output logic                                  out_last_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        EMIT
    } state_e;

    state_e                                  state_q, state_d;
    logic [LITERAL_ADDRESS_WIDTH-1:0]        lit_q, lit_d;
    logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0]   base_q, base_d;
    logic [CLAUSE_COUNT-1:0]                 mask_q, mask_d;
    logic                                    done_q, done_d;

    logic [CLAUSE_INDEX_WIDTH-1:0]           idx;
    logic [CLAUSE_COUNT-1:0]                 mask_rest;
    logic                                    last;
    logic                                    emit;

    // Descending scan so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = CLAUSE_COUNT - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                idx = CLAUSE_INDEX_WIDTH'(i);
            end
        end
    end

    assign mask_rest = mask_q & (mask_q - CLAUSE_COUNT'(1));
    assign last      = (mask_rest == '0);
    assign emit      = (state_q == EMIT);

    always_comb begin
        state_d = state_q;
        lit_d   = lit_q;
        base_d  = base_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    lit_d   = req_literal_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                base_d = att_addr_i;
                mask_d = att_mask_i;
                if (att_mask_i == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready_i) begin
                    mask_d = mask_rest;
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lit_q   <= '0;
            base_q  <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lit_q   <= lit_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
        end
    end

    // Address wraps modulo the clause-table size.
    assign out_clause_addr_o = emit
        ? base_q + CLAUSE_TABLE_ADDRESS_WIDTH'(idx) : '0;
    assign out_clause_idx_o  = emit ? idx : '0;
    assign out_last_o        = emit && last;
    assign out_valid_o       = emit;
    assign req_ready_o       = (state_q == IDLE);
    assign busy_o            = (state_q != IDLE);
    assign done_o            = done_q;
    assign att_rd_addr_o     = lit_q;

endmodule

// File: tb/tb_att_clause_walker.sv
// Directed bench for att_clause_walker with a registered-read table model.
module tb_att_clause_walker;

    localparam int CC   = 20;
    localparam int LAW  = 12;
    localparam int CTAW = 11;
    localparam int CIW  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [LAW-1:0]  req_literal;
    logic [LAW-1:0]  att_rd_addr;
    logic [CTAW-1:0] att_addr;
    logic [CC-1:0]   att_mask;
    logic            out_valid;
    logic            out_ready;
    logic [CTAW-1:0] out_addr;
    logic [CIW-1:0]  out_idx;
    logic            out_last;
    logic            busy;
    logic            done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    att_clause_walker dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_literal_i     (req_literal),
        .att_rd_addr_o     (att_rd_addr),
        .att_addr_i        (att_addr),
        .att_mask_i        (att_mask),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_clause_addr_o (out_addr),
        .out_clause_idx_o  (out_idx),
        .out_last_o        (out_last),
        .busy_o            (busy),
        .done_o            (done)
    );

    // Table: data valid the cycle after the read address is sampled.
    always @(posedge clk) begin
        case (att_rd_addr)
            12'd5: begin
                att_addr <= 11'd100;
                att_mask <= 20'h000A1;
            end
            12'd9: begin
                att_addr <= 11'd37;
                att_mask <= 20'h00000;
            end
            12'd3: begin
                att_addr <= 11'd2040;
                att_mask <= 20'h80400;
            end
            default: begin
                att_addr <= 11'd0;
                att_mask <= 20'h00000;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a descriptor check for the current cycle, then advance.
    task automatic expect_desc(input string tag, input int a, input int i,
                               input int l);
        check({tag, ".valid"}, 32'(out_valid), 1);
        check({tag, ".addr"}, 32'(out_addr), a);
        check({tag, ".idx"}, 32'(out_idx), i);
        check({tag, ".last"}, 32'(out_last), l);
        check({tag, ".done"}, 32'(done), 0);
        tick();
    endtask

    // Accept a literal and step through ISSUE and CAPTURE.
    task automatic accept(input string tag, input int lit);
        req_valid   = 1'b1;
        req_literal = LAW'(lit);
        check({tag, ".ready"}, 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        check({tag, ".issue_v"}, 32'(out_valid), 0);
        check({tag, ".busy"}, 32'(busy), 1);
        tick();
        check({tag, ".capt_v"}, 32'(out_valid), 0);
        tick();
    endtask

    task automatic expect_done(input string tag);
        check({tag, ".done"}, 32'(done), 1);
        check({tag, ".v_off"}, 32'(out_valid), 0);
        check({tag, ".ready"}, 32'(req_ready), 1);
        tick();
        check({tag, ".done_1"}, 32'(done), 0);
    endtask

    initial begin
        int exp_a [3];
        int exp_i [3];
        int k;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_literal = '0;
        out_ready   = 1'b1;
        #12;
        check("rst.valid", 32'(out_valid), 0);
        check("rst.done", 32'(done), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.last", 32'(out_last), 0);
        check("rst.rdaddr", 32'(att_rd_addr), 0);
        rst_n = 1'b1;
        tick();
        check("rst.ready", 32'(req_ready), 1);

        accept("l5", 5);
        check("l5.rdaddr", 32'(att_rd_addr), 5);
        expect_desc("l5.d0", 100, 0, 0);
        expect_desc("l5.d1", 105, 5, 0);
        expect_desc("l5.d2", 107, 7, 1);
        expect_done("l5");

        accept("l9", 9);
        expect_done("l9");

        // Backpressure: stall 4 cycles, then toggle ready.
        exp_a = '{100, 105, 107};
        exp_i = '{0, 5, 7};
        out_ready = 1'b0;
        accept("bp", 5);
        k = 0;
        for (int c = 0; c < 30 && k < 3; c++) begin
            out_ready = (c >= 4) && c[0];
            check("bp.valid", 32'(out_valid), 1);
            check("bp.addr", 32'(out_addr), exp_a[k]);
            check("bp.idx", 32'(out_idx), exp_i[k]);
            check("bp.last", 32'(out_last), (k == 2) ? 1 : 0);
            if (out_ready) k++;
            tick();
        end
        check("bp.count", 32'(k), 3);
        out_ready = 1'b1;
        expect_done("bp");

        accept("wrap", 3);
        expect_desc("wrap.d0", 2, 10, 0);
        expect_desc("wrap.d1", 11, 19, 1);
        expect_done("wrap");

        // Back-to-back: literal 9 waits behind literal 5.
        req_valid   = 1'b1;
        req_literal = 12'd5;
        check("b2b.ready0", 32'(req_ready), 1);
        tick();
        req_literal = 12'd9;
        check("b2b.hold_rdy", 32'(req_ready), 0);
        tick();
        tick();
        expect_desc("b2b.d0", 100, 0, 0);
        check("b2b.rdaddr", 32'(att_rd_addr), 5);
        expect_desc("b2b.d1", 105, 5, 0);
        expect_desc("b2b.d2", 107, 7, 1);
        check("b2b.done5", 32'(done), 1);
        check("b2b.ready5", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        check("b2b.busy9", 32'(busy), 1);
        check("b2b.done_off", 32'(done), 0);
        check("b2b.rdaddr9", 32'(att_rd_addr), 9);
        tick();
        check("b2b.capt_v", 32'(out_valid), 0);
        tick();
        expect_done("b2b9");

        // Asynchronous reset while the third descriptor is pending.
        accept("rm", 5);
        expect_desc("rm.d0", 100, 0, 0);
        expect_desc("rm.d1", 105, 5, 0);
        check("rm.pre_v", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm.async_v", 32'(out_valid), 0);
        check("rm.async_busy", 32'(busy), 0);
        tick();
        check("rm.no_done", 32'(done), 0);
        rst_n = 1'b1;
        tick();
        check("rm.ready", 32'(req_ready), 1);
        check("rm.no_done2", 32'(done), 0);
        accept("rm2", 5);
        expect_desc("rm2.d0", 100, 0, 0);
        expect_desc("rm2.d1", 105, 5, 0);
        expect_desc("rm2.d2", 107, 7, 1);
        expect_done("rm2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/att_clause_walker.md
Name: att_clause_walker

Overview:
- Runtime reader for Address_Translation_Table. Accepts one literal request at a time and issues the table read.
- Captures the table's clause-table base address and clause mask.
- Emits one clause descriptor per set mask bit, lowest bit first, on a valid/ready stream to the downstream clause evaluation logic.
- Sits between the flip/selection logic, which supplies literals, and the clause table readers.

Parameters:
- CLAUSE_COUNT, 20, mask width; must match the table.
- LITERAL_ADDRESS_WIDTH, 12, literal/table read address width.
- CLAUSE_TABLE_ADDRESS_WIDTH, 11, width of the base address and of the emitted clause address.
- CLAUSE_INDEX_WIDTH, localparam = $clog2(CLAUSE_COUNT), emitted bit-index width.

Ports:
- clk_i  in  1  single clock; all logic on posedge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  literal request valid.
- req_ready_o  out  1  block can accept a request.
- req_literal_i  in  LITERAL_ADDRESS_WIDTH  literal to look up.
- att_rd_addr_o  out  LITERAL_ADDRESS_WIDTH  drives table rd_addr_i.
- att_addr_i  in  CLAUSE_TABLE_ADDRESS_WIDTH  table addr_o.
- att_mask_i  in  CLAUSE_COUNT  table mask_o.
- out_valid_o  out  1  clause descriptor valid.
- out_ready_i  in  1  downstream accepts the descriptor.
- out_clause_addr_o  out  CLAUSE_TABLE_ADDRESS_WIDTH  base + bit index.
- out_clause_idx_o  out  CLAUSE_INDEX_WIDTH  mask bit index.
- out_last_o  out  1  final descriptor of the current request.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when a request completes.

Behaviour:
- Reset (rst_ni low, async): state=IDLE; lit_q, base_q, mask_q = 0; out_valid_o=0, out_last_o=0, done_o=0, busy_o=0. att_rd_addr_o=0 and outputs 0. req_ready_o=1 once in IDLE. Reset at any point mid-request discards the request without a done_o pulse.
- req_ready_o = (state==IDLE). A request transfers on req_valid_i && req_ready_o; lit_q<=req_literal_i; state→ISSUE.
- att_rd_addr_o = lit_q, registered; it never changes outside an accept.
- ISSUE, 1 cycle: the table samples lit_q at the end of this cycle. State→CAPTURE.
- CAPTURE, 1 cycle: att_addr_i and att_mask_i are valid. base_q<=att_addr_i, mask_q<=att_mask_i.
  - If att_mask_i==0: done_o pulses the next cycle and state→IDLE.
  - Otherwise state→EMIT.
- EMIT:
  - out_valid_o=1.
  - idx = lowest set bit of mask_q (priority encode, bit 0 highest priority).
  - out_clause_idx_o=idx.
  - out_clause_addr_o = (base_q + idx) truncated to CLAUSE_TABLE_ADDRESS_WIDTH (wraps modulo 2^width, no error flag).
  - out_last_o=1 iff mask_q has exactly one set bit.
- EMIT handshake (out_valid_o && out_ready_i): clear bit idx of mask_q.
  - If out_last_o: state→IDLE and done_o pulses the next cycle.
  - Otherwise the next descriptor is presented the following cycle, giving one descriptor per cycle under continuous out_ready_i.
- Stability: while out_valid_o && !out_ready_i, all out_* stay constant. out_valid_o never drops without a handshake, except on reset.
- done_o is registered and high for exactly one cycle, in the cycle the block is back in IDLE. A new request may be accepted in that same cycle.
- Latency: accept edge → first out_valid_o is 3 cycles (ISSUE, CAPTURE, EMIT). Zero-mask request: accept → done_o is 3 cycles.
- No request queueing; req_valid_i held outside IDLE is ignored until IDLE.
- The table write port is untouched. The loader must not write the table while busy_o=1; the walker does not check this.
- Mask bits at index ≥ CLAUSE_COUNT do not exist. CLAUSE_COUNT=1 must synthesize, with CLAUSE_INDEX_WIDTH clamped to ≥1.

Test Plan:
- Table[5] = base 100, mask 0x000A1 (bits 0,5,7); request literal 5, out_ready_i=1 → descriptors (100,0), (105,5), (107,7) on consecutive cycles; out_last_o only on the third; done_o 1 cycle later; first valid 3 cycles after accept.
- Table[9] = base 37, mask 0 → no out_valid_o; done_o pulses 3 cycles after accept; req_ready_o high again.
- Backpressure: table[5] as above, out_ready_i low 4 cycles then toggling → (100,0) held stable while stalled; no descriptor lost or duplicated; same three descriptors emitted in order.
- Wrap: table[3] = base 2040, mask bit 10 and bit 19 → addresses 2050 mod 2048 = 2 and 2059 mod 2048 = 11; indices 10 and 19; last on idx 19.
- Back-to-back: request literal 5, then literal 9 presented continuously → literal 9 accepted in the done_o cycle of literal 5; its done_o follows 3 cycles later.
- Reset mid-EMIT: assert rst_ni low after the 2nd descriptor of literal 5 → out_valid_o drops immediately (async); no done_o pulse; after release the block is in IDLE with req_ready_o=1, and a fresh request for literal 5 emits all three descriptors.
